// File: rtl/buf_display_pkg.sv
// Shared constants and the BCD to 7-segment decode for the keypad entry buffer.
package buf_display_pkg;

    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [3:0] K_BACK  = 4'hB;
    localparam logic [3:0] K_CLR   = 4'hC;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Segments {g,f,e,d,c,b,a}, active-low; anything above 9 is blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/buf_display_scan_7seg.sv
// Time-multiplexed scanner: each of the four digits is driven for DIV clocks.
module scan_7seg
    import buf_display_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] valor,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          wrap;

    // an/seg come from the same register stage so they always switch together.
    always_comb begin
        wrap      = (div_cnt_q == CW'(DIV - 1));
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        an_d      = ~(4'b0001 << idx_q);
        seg_d     = bcd_to_seg(valor[4*idx_q +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: rtl/buf_display.sv
// Keypad entry buffer: 4-digit BCD shift-in/backspace/clear, scanned onto a 7-segment display.
module buf_display
    import buf_display_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  digito,
    output logic [15:0] valor,
    output logic [2:0]  cuenta,
    output logic        lleno,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic        dprev_q, dprev_d;
    logic [15:0] valor_q, valor_d;
    logic [2:0]  cuenta_q, cuenta_d;
    logic        press;
    logic [3:0]  code;

    always_comb begin
        dprev_d  = digito[4];
        valor_d  = valor_q;
        cuenta_d = cuenta_q;
        code     = digito[3:0];
        press    = digito[4] & ~dprev_q;
        if (press) begin
            if (code <= 4'd9) begin
                if (cuenta_q != 3'd4) begin
                    valor_d  = {valor_q[11:0], code};
                    cuenta_d = cuenta_q + 3'd1;
                end
            end else if (code == K_BACK) begin
                if (cuenta_q != 3'd0) begin
                    valor_d  = {BLANK, valor_q[15:4]};
                    cuenta_d = cuenta_q - 3'd1;
                end
            end else if (code == K_CLR) begin
                valor_d  = {4{BLANK}};
                cuenta_d = 3'd0;
            end
        end
    end

    // A key still held across reset is seen again as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dprev_q  <= 1'b0;
            valor_q  <= {4{BLANK}};
            cuenta_q <= 3'd0;
        end else begin
            dprev_q  <= dprev_d;
            valor_q  <= valor_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign valor  = valor_q;
    assign cuenta = cuenta_q;
    assign lleno  = (cuenta_q == 3'd4);

    scan_7seg #(.DIV(DIV)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .valor (valor_q),
        .an    (an),
        .seg   (seg)
    );

endmodule

// File: tb/tb_buf_display.sv
// Directed bench for buf_display with DIV = 4; expected values are hand-computed.
module tb_buf_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  digito = 5'd0;
    logic [15:0] valor;
    logic [2:0]  cuenta;
    logic        lleno;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_chk  = 0;
    int n_fail = 0;

    buf_display #(.DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .digito (digito),
        .valor  (valor),
        .cuenta (cuenta),
        .lleno  (lleno),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        @(negedge clk);
        digito = {1'b1, code};
        repeat (hold) @(negedge clk);
        digito = 5'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_buf(input string tag, input logic [15:0] v, input logic [2:0] c, input logic l);
        chk({tag, "_valor"}, 32'(valor), 32'(v));
        chk({tag, "_cuenta"}, 32'(cuenta), 32'(c));
        chk({tag, "_lleno"}, 32'(lleno), 32'(l));
    endtask

    // Wait (bounded) for each digit's slot and compare its segments.
    task automatic scan_chk(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_s [4];
        logic [3:0] tgt;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            tgt = ~(4'b0001 << k);
            while (an !== tgt && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_an"}, 32'(an), 32'(tgt));
            chk({tag, "_seg"}, 32'(seg), 32'(exp_s[k]));
        end
    endtask

    initial begin
        logic [3:0] an_exp [4];
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;

        // 1: asynchronous reset mid-cycle, then scan order with a blank display
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'(4'b1111));
        chk("rst_seg", 32'(seg), 32'(7'b1111111));
        chk_buf("rst", 16'hFFFF, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("scan_step_an", 32'(an), 32'(an_exp[i/4]));
            chk("scan_step_seg", 32'(seg), 32'(7'b1111111));
        end

        // 2: digit entry; buffer is visible one cycle after the key goes down
        @(negedge clk);
        digito = 5'b1_0001;
        @(negedge clk);
        chk("latency_cuenta", 32'(cuenta), 32'd1);
        chk("latency_valor", 32'(valor), 32'h0000FFF1);
        repeat (4) @(negedge clk);
        digito = 5'd0;
        repeat (3) @(negedge clk);
        press(4'd2, 5);
        press(4'd3, 5);
        chk_buf("entry", 16'hF123, 3'd3, 1'b0);
        scan_chk("entry", 7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111);

        // 3: long hold adds one digit, fifth digit ignored when full
        press(4'd4, 20);
        chk_buf("hold4", 16'h1234, 3'd4, 1'b1);
        press(4'd5, 5);
        chk_buf("full5", 16'h1234, 3'd4, 1'b1);
        scan_chk("full", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // 4: backspace
        press(4'hB, 5);
        press(4'hB, 5);
        chk_buf("back2", 16'hFF12, 3'd2, 1'b0);

        // 5: clear, ignored code, backspace on empty, decode of 9
        press(4'hC, 5);
        chk_buf("clear", 16'hFFFF, 3'd0, 1'b0);
        press(4'hA, 5);
        chk_buf("ign_A", 16'hFFFF, 3'd0, 1'b0);
        press(4'hB, 5);
        chk_buf("back_empty", 16'hFFFF, 3'd0, 1'b0);
        press(4'd9, 5);
        chk_buf("nine", 16'hFFF9, 3'd1, 1'b0);
        scan_chk("nine", 7'b0010000, 7'b1111111, 7'b1111111, 7'b1111111);

        // 6: reset pulse while a key is held re-detects that key
        @(negedge clk);
        digito = 5'b1_0111;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_buf("midrst_in", 16'hFFFF, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_buf("midrst_out", 16'hFFF7, 3'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk_buf("midrst_hold", 16'hFFF7, 3'd1, 1'b0);
        digito = 5'd0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buf_display.md
# buf_display

Keypad entry buffer and 7-segment display scanner, directly downstream of the keypad driver. Captures each new key press from the driver's `digito` output, maintains a 4-digit BCD entry (shift-in, backspace, clear) and time-multiplexes it onto a 4-digit common-anode 7-segment display. Also exports the entered value for downstream arithmetic.

## Interface

**Parameters**
- `DIV`, default 50000: scan divider, in clk cycles per displayed digit. Must be ≥ 2.

**Ports**
- `clk` (in, 1): system clock, the same clock as the keypad driver.
- `rst` (in, 1): asynchronous, active-high reset.
- `digito` (in, 5): from the keypad driver. `digito[4]` is high while a key is held; `digito[3:0]` is the key code, valid while `digito[4]` is high.
- `valor` (out, 16): entered digits, BCD. `[3:0]` is the most recent digit. A blank position reads 4'hF.
- `cuenta` (out, 3): number of digits entered, 0 to 4.
- `lleno` (out, 1): high when `cuenta` == 4.
- `an` (out, 4): digit enables, active-low. `an[0]` is the rightmost digit.
- `seg` (out, 7): segments `{g,f,e,d,c,b,a}`, active-low.

## Operation

**Press detection**
- Register `dprev` <= `digito[4]`.
- `press` = `digito[4] & ~dprev`. Exactly one event per press, regardless of hold length.

**Actions on press, by code**
- 0 to 9: if `cuenta` < 4, shift left. Then `valor` <= {`valor[11:0]`, code} and `cuenta`++. If `cuenta` == 4, the press is ignored and `valor` is unchanged.
- 4'hB (backspace): if `cuenta` > 0, `valor` <= {4'hF, `valor[15:4]`} and `cuenta`--. Otherwise no-op.
- 4'hC (clear): `valor` <= 16'hFFFF and `cuenta` <= 0.
- 4'hA, 4'hD, 4'hE, 4'hF: ignored.

**Scanning**
- `div_cnt` counts 0 to DIV-1 and wraps.
- On wrap, `idx` (2 bits) increments mod 4.
- Each cycle, registered outputs take:
  - `an` <= ~(4'b0001 << `idx`)
  - `seg` <= decode(`valor[4*idx +: 4]`)
- Decode: 0 to 9 use standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000). Any value > 9 gives blank, 7'b1111111.

**Reset (asynchronous, any time including mid-press)**
- `valor` = 16'hFFFF, `cuenta` = 0, `lleno` = 0, `dprev` = 0.
- `div_cnt` = 0, `idx` = 0.
- `an` = 4'b1111, `seg` = 7'b1111111.
- If a key is still held when reset releases, `dprev` = 0 means it registers as a new press on the first clock edge with `digito[4]` high. This is accepted behaviour.

## Timing

- **Press to buffer:** `valor`, `cuenta` and `lleno` update on the clock edge where `press` = 1. That is the first edge at which `digito[4]` is sampled high, so they are visible one cycle after `digito[4]` rises.
- **Buffer to display:** `seg` reflects a new `valor` no later than one cycle after the update if that digit is being scanned. Otherwise it appears at the digit's next scan slot, within 4·DIV cycles.
- **Digit switching:** `an` and `seg` are from one register stage and change on the same edge. Each digit is enabled for exactly DIV cycles, cycling 0,1,2,3,0…
- **First clock after reset:** `an` = 4'b1110, `seg` = blank.
- **Back-to-back presses:** require `digito[4]` low for at least 1 cycle between them. A release-and-press within one cycle is not a supported input.
- **`lleno`:** combinational from `cuenta`, so it has no extra latency.

## Structure

- Shared package holds:
  - `BLANK` = 4'hF
  - key constants `K_BACK` = 4'hB and `K_CLR` = 4'hC
  - `SEG_OFF` = 7'b1111111
  - the BCD-to-7-segment function
- One natural sub-module, `scan_7seg`. It contains `div_cnt`, `idx`, the `an`/`seg` registers and the decode. Inputs: `clk`, `rst`, `valor`. Outputs: `an`, `seg`.
- Edge detect and buffer logic stay in `buf_display`.

## Test plan

All scenarios use DIV = 4.

1. **Reset:** assert `rst` asynchronously mid-cycle, then release → `valor` = 16'hFFFF, `cuenta` = 0, `an` = 4'b1111 during reset. After release, `an` steps 1110→1101→1011→0111 every 4 cycles and `seg` = 7'b1111111 throughout.
2. **Digit entry:** press 1, 2, 3 (each held 5 cycles, then 3 low) → `valor` = 16'hF123, `cuenta` = 3. When `an` = 4'b1110, `seg` = 7'b0110000 (digit 3). Holding a key for 20 cycles adds only one digit.
3. **Full:** press 4 and then 5 after (2) → `valor` = 16'h1234, `lleno` = 1. The press of 5 leaves `valor` unchanged.
4. **Backspace:** press B twice after (3) → `valor` = 16'hFF12, `cuenta` = 2. Backspace with `cuenta` = 0 → no change.
5. **Clear:** with `valor` = 16'hFF12, press C → 16'hFFFF, `cuenta` = 0. Press A → no change.
6. **Reset mid-press:** pulse `rst` while `digito` = 5'b1_0111 is held → after release, `valor` = 16'hFFF7 and `cuenta` = 1. This is the re-detected press.
